// File: rtl/uart_tx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_if
//
// Purpose:
//   Bundles the connection between the transmit FIFO and a Uart8 transmitter.
//   The FIFO is the master: it drives enable, start and the byte to send.
//   The Uart8 is the slave: it reports busy and frame-done back.
//
// Signals:
//   txEn     FIFO -> Uart8   transmitter enable
//   txStart  FIFO -> Uart8   level request, held while bytes are pending
//   txIn     FIFO -> Uart8   byte at the head of the FIFO
//   txBusy   Uart8 -> FIFO   frame in progress
//   txDone   Uart8 -> FIFO   level, high at the end of a frame
//
// Modports:
//   master   used by uart_tx_fifo
//   slave    used by the Uart8 (or a model of it)
// ---------------------------------------------------------------------------
interface uart_tx_fifo_if;

  logic       txEn;
  logic       txStart;
  logic [7:0] txIn;
  logic       txBusy;
  logic       txDone;

  modport master (
    output txEn,
    output txStart,
    output txIn,
    input  txBusy,
    input  txDone
  );

  modport slave (
    input  txEn,
    input  txStart,
    input  txIn,
    output txBusy,
    output txDone
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// Purpose:
//   Transmit-side circular buffer sitting directly in front of a Uart8
//   transmitter. The host pushes bytes with a write strobe; the block keeps
//   txStart high while anything is queued and presents the head byte on
//   txIn. Each rising edge of the Uart8 txDone pops the head so that the
//   next byte is already on txIn when the Uart8 loops back into its
//   start-bit state. Back-to-back bytes therefore go out without any host
//   pacing, and each byte is sent exactly once.
//
// Parameters:
//   DEPTH_LOG2   log2 of the FIFO depth (default 4 -> 16 entries)
//   AE_LEVEL     almost-empty threshold, only used by the level IRQ option
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset        asynchronous, active-high reset
//   en           block enable, forwarded to Uart8 txEn
//   flush        synchronous clear of the FIFO contents and overflow flag
//   wrEn         write strobe, one byte per cycle
//   wrData       byte to enqueue
//   full         FIFO holds DEPTH entries
//   empty        FIFO holds no entries
//   count        occupancy, 0..DEPTH
//   overflow     sticky, set when a write is dropped because the FIFO is full
//   almostEmpty  occupancy at or below AE_LEVEL and the Uart8 is between
//                frames (only with the option macro below)
//   uart         master side of uart_tx_fifo_if towards the Uart8
//
// Build option:
//   UART_TX_FIFO_LEVEL_IRQ_EN  when defined, adds the almostEmpty output and
//                              its comparator; when undefined neither exists.
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  wrEn,
  input  logic [7:0]            wrData,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
`ifdef UART_TX_FIFO_LEVEL_IRQ_EN
  output logic                  almostEmpty,
`endif
  uart_tx_fifo_if.master        uart
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Occupancy value meaning "completely full", built without integer
  // truncation so it matches the width of count exactly.
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  // Storage and pointers. Pointers are exactly DEPTH_LOG2 bits wide so they
  // wrap modulo DEPTH on their own; occupancy is kept in a separate counter.
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rdPtr;
  logic [DEPTH_LOG2-1:0] wrPtr;

  // Registered copies of the outputs towards the Uart8.
  logic                  txEnQ;
  logic                  txStartQ;
  logic [7:0]            txInQ;

  // Previous txDone level, used to turn the level into a one-cycle pulse.
  logic                  txDoneQ;

  // Combinational next-state terms.
  logic                  donePulse;
  logic                  pop;
  logic                  isFull;
  logic                  wrAccept;
  logic                  wrDrop;
  logic                  bypass;
  logic [DEPTH_LOG2-1:0] nextRdPtr;
  logic [DEPTH_LOG2-1:0] nextWrPtr;
  logic [DEPTH_LOG2:0]   nextCount;
  logic [7:0]            nextHead;

  // Pop, write-accept and pointer/count next-state logic.
  // A pop needs a fresh txDone rising edge and something to pop; a done
  // pulse on an empty FIFO (for example the tail of a frame that was in
  // flight when the FIFO was flushed) is ignored. When full, a write only
  // gets in if a pop frees the slot in the same cycle. flush wins over
  // everything, including a same-cycle write, which is silently discarded.
  // The head byte for the next cycle comes from the new read pointer, except
  // when the byte being written right now becomes the head (empty FIFO, or
  // last entry popped in the same cycle): the memory write has not happened
  // yet, so wrData is bypassed straight to txIn.
  always_comb begin
    donePulse = 1'b0;
    pop       = 1'b0;
    isFull    = 1'b0;
    wrAccept  = 1'b0;
    wrDrop    = 1'b0;
    bypass    = 1'b0;
    nextRdPtr = rdPtr;
    nextWrPtr = wrPtr;
    nextCount = count;
    nextHead  = 8'h00;

    donePulse = uart.txDone & ~txDoneQ;
    pop       = donePulse && (count != '0);
    isFull    = (count == FULL_COUNT);
    wrAccept  = wrEn && !flush && (!isFull || pop);
    wrDrop    = wrEn && !flush && isFull && !pop;

    if (pop) begin
      nextRdPtr = rdPtr + 1'b1;
    end
    if (wrAccept) begin
      nextWrPtr = wrPtr + 1'b1;
    end

    case ({wrAccept, pop})
      2'b10:   nextCount = count + 1'b1;
      2'b01:   nextCount = count - 1'b1;
      default: nextCount = count;
    endcase

    bypass = wrAccept && (nextRdPtr == wrPtr);

    if (flush) begin
      nextRdPtr = '0;
      nextWrPtr = '0;
      nextCount = '0;
      bypass    = 1'b0;
    end

    nextHead = bypass ? wrData : mem[nextRdPtr];
  end

  // Byte storage. Contents are not reset: occupancy and pointers define
  // which entries are valid, so stale data is never presented as pending.
  always_ff @(posedge clk) begin
    if (wrAccept) begin
      mem[wrPtr] <= wrData;
    end
  end

  // Pointer, occupancy and status flag registers. overflow is sticky and
  // only cleared by reset or flush; a write discarded by flush does not
  // count as a drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
      txDoneQ  <= 1'b0;
    end else begin
      rdPtr    <= nextRdPtr;
      wrPtr    <= nextWrPtr;
      count    <= nextCount;
      empty    <= (nextCount == '0);
      full     <= (nextCount == FULL_COUNT);
      txDoneQ  <= uart.txDone;
      if (flush) begin
        overflow <= 1'b0;
      end else if (wrDrop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Outputs towards the Uart8, registered from next-state values so they
  // line up with count on the cycle after the causing event. txStart is a
  // level: the Uart8 keeps looping into a new frame while it is high, and it
  // drops the cycle after the last byte is popped. Deasserting en stops new
  // frames but leaves the FIFO untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txEnQ    <= 1'b0;
      txStartQ <= 1'b0;
      txInQ    <= 8'h00;
    end else begin
      txEnQ    <= en;
      txStartQ <= en && (nextCount != '0);
      txInQ    <= nextHead;
    end
  end

  assign uart.txEn    = txEnQ;
  assign uart.txStart = txStartQ;
  assign uart.txIn    = txInQ;

`ifdef UART_TX_FIFO_LEVEL_IRQ_EN
  localparam logic [DEPTH_LOG2:0] AE_COUNT = AE_LEVEL[DEPTH_LOG2:0];

  logic txBusyQ;
  logic levelLowQ;

  // Almost-empty tracking. The level term follows the next occupancy so it
  // is aligned with count; the busy term masks the flag while a frame is on
  // the line, so the host is prompted to refill only between frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txBusyQ   <= 1'b0;
      levelLowQ <= 1'b0;
    end else begin
      txBusyQ   <= uart.txBusy;
      levelLowQ <= (nextCount <= AE_COUNT);
    end
  end

  assign almostEmpty = levelLowQ & ~txBusyQ;
`endif

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side buffer that sits directly upstream of Uart8's tx interface.
- Accepts bytes from a host-side write strobe into a circular FIFO.
- Drives Uart8 txEn/txStart/txIn and pops the head byte each time Uart8 reports txDone, so back-to-back bytes go out without host pacing.
- Output of this block connects straight to a Uart8 instance: txEn, txStart, txIn in; txBusy, txDone out.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth; depth = 16 entries.
- AE_LEVEL, 2, almost-empty threshold; used only with the optional feature.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  block enable; passed to Uart8 txEn.
- flush  input  1  synchronous clear of FIFO contents.
- wrEn  input  1  write strobe; one byte per cycle when high.
- wrData  input  8  byte to enqueue.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when a write is dropped.
- txEn  output  1  to Uart8 txEn.
- txStart  output  1  to Uart8 txStart; level, held while data is pending.
- txIn  output  8  to Uart8 txIn; current head byte.
- txBusy  input  1  from Uart8.
- txDone  input  1  from Uart8; level, high at end of frame.
- almostEmpty  output  1  present only with UART_TX_FIFO_LEVEL_IRQ_EN.

Behaviour:
- Reset (async, active-high):
  - Pointers and count go to 0; empty=1, full=0, overflow=0.
  - txStart=0, txIn=8'h00, txEn=0.
  - Asserting reset mid-frame abandons the FIFO contents; Uart8 finishes or aborts per its own rules.
- Storage: DEPTH×8 register array; rdPtr/wrPtr are DEPTH_LOG2 bits and wrap modulo DEPTH; count is a separate register.
- Write: accepted when wrEn=1 and (count<DEPTH, or a pop occurs in the same cycle).
  - A write with wrEn=1 while full and no pop is dropped and sets overflow.
  - overflow clears only on reset or flush.
- Pop detection: a registered copy of txDone yields a one-cycle pulse donePulse = txDone & ~txDone_q.
  - Pop occurs when donePulse=1 and count>0.
  - donePulse with count=0 is ignored.
- Simultaneous write and pop: both happen; count unchanged. When full, this is the only way a write is accepted.
- Outputs (all registered, updated on the clock after the causing event):
  - txEn = en.
  - txStart = en & (next count != 0).
  - txIn = mem[next rdPtr]. A write into an empty FIFO presents wrData on txIn the next cycle (bypass).
  - Write at cycle N into an empty FIFO, with en=1: empty=0, count=1, txIn=byte, txStart=1 at N+1.
- Sequencing with Uart8:
  - Uart8 latches txIn on entry to its start-bit state.
  - Uart8 loops back to send again while txStart stays high.
  - The pop updates txIn one cycle after the txDone rising edge, before Uart8 re-enters start-bit, so each byte is sent exactly once.
  - When the last byte's donePulse pops it, txStart falls the next cycle.
- en=0 forces txStart=0 and txEn=0. FIFO contents are retained and writes are still accepted.
- flush (synchronous):
  - Next cycle: pointers=0, count=0, empty=1, overflow=0, txStart=0.
  - A byte already latched by Uart8 completes on the line; its later txDone is ignored because count=0.
  - flush has priority over a same-cycle wrEn; that write is discarded without setting overflow.
- txBusy is not used for control. It is registered only for the optional feature and debug.

Optional Feature:
- Macro: UART_TX_FIFO_LEVEL_IRQ_EN.
- Defined: almostEmpty port exists.
  - almostEmpty = registered (count <= AE_LEVEL) & ~txBusy_q.
  - It goes high once the FIFO has drained to the threshold and the UART is between frames, so the host can refill.
- Undefined: the port is absent and no comparator logic is generated.

Test Plan:
- Reset then idle → empty=1, count=0, txStart=0, txIn=8'h00, overflow=0 with reset held and after release.
- en=1; write 8'h7A at cycle N into the empty FIFO → at N+1: txStart=1, txIn=8'h7A, count=1. After the loop-back Uart8 receiver's rxDone, rxOut=8'h7A; txStart=0 one cycle after txDone rises.
- Write 8'h7A, 8'hB1, 8'h3C back-to-back → receiver sees exactly 7A, B1, 3C in order with no duplicate frame; count goes 3→2→1→0 on successive txDone edges.
- en=1 with the Uart8 txDone input held low (no frame completes, FIFO never drains) while writing 17 bytes → full=1 after the 16th, the 17th is dropped, overflow=1, count=16. Then a write in the same cycle as a pop → accepted, count stays 16.
- Flush mid-frame with 5 bytes queued → next cycle count=0, txStart=0, overflow=0; the in-flight byte completes on the line; no further bytes are sent.
- With UART_TX_FIFO_LEVEL_IRQ_EN and AE_LEVEL=2, queue 4 bytes → almostEmpty rises after the second pop, while txBusy=0 between frames.
